// File: rtl/apu_disp_pkg.sv
// Shared types for the APU dispatcher: latency classes and the queued-op entry.
// Entry address field is sized for the widest supported ADDR_W (ADDR_W <= ENTRY_ADDR_W).
package apu_disp_pkg;

  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,
    LAT_1    = 2'd1,
    LAT_2    = 2'd2,
    LAT_MC   = 2'd3
  } lat_t;

  localparam int unsigned ENTRY_ADDR_W = 16;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    lat_t                    lat;
  } entry_t;

endpackage

// File: rtl/apu_disp_queue.sv
// In-order circular queue of outstanding multicycle ops plus per-entry register dependency compare.
// Push at tail, pop at head; an entry popping this cycle no longer reports a dependency.
module apu_disp_queue
  import apu_disp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  entry_t                       push_entry_i,
  input  logic                         pop_i,
  input  logic [N_RD-1:0][ADDR_W-1:0]  read_regs_i,
  input  logic [N_RD-1:0]              read_regs_valid_i,
  input  logic [N_WR-1:0][ADDR_W-1:0]  write_regs_i,
  input  logic [N_WR-1:0]              write_regs_valid_i,
  output logic [ADDR_W-1:0]            head_addr_o,
  output lat_t                         head_lat_o,
  output logic [CNT_W-1:0]             occupancy_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         read_dep_o,
  output logic                         write_dep_o
);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   w_live;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: only slots inside the live window are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_entry_i;
  end

  // A slot is live when its distance from head is below the count and it is not leaving now.
  always_comb begin
    logic [PTR_W-1:0] off;
    off    = '0;
    w_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = PTR_W'(i) - r_rd_ptr;
      w_live[i] = ({1'b0, off} < r_count) && !((off == '0) && pop_i);
    end
  end

  always_comb begin
    read_dep_o  = 1'b0;
    write_dep_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < N_RD; j++) begin
        if (w_live[i] && read_regs_valid_i[j] &&
            (r_mem[i].addr == ENTRY_ADDR_W'(read_regs_i[j])))
          read_dep_o = 1'b1;
      end
      for (int k = 0; k < N_WR; k++) begin
        if (w_live[i] && write_regs_valid_i[k] &&
            (r_mem[i].addr == ENTRY_ADDR_W'(write_regs_i[k])))
          write_dep_o = 1'b1;
      end
    end
  end

  assign head_addr_o = r_mem[r_rd_ptr].addr[ADDR_W-1:0];
  assign head_lat_o  = r_mem[r_rd_ptr].lat;
  assign occupancy_o = r_count;
  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/riscv_apu_disp_mq.sv
// APU dispatcher: issues requests, tracks outstanding multicycle ops in order, flags hazards and stalls.
// Optional saturating stall counters are built when APU_DISP_PERF_EN is defined.
module riscv_apu_disp_mq
  import apu_disp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [1:0]                    apu_lat_i,
  input  logic [ADDR_W-1:0]             apu_waddr_i,
  input  logic [N_RD-1:0][ADDR_W-1:0]   read_regs_i,
  input  logic [N_RD-1:0]               read_regs_valid_i,
  input  logic [N_WR-1:0][ADDR_W-1:0]   write_regs_i,
  input  logic [N_WR-1:0]               write_regs_valid_i,
  output logic                          apu_master_req_o,
  output logic                          apu_master_ready_o,
  input  logic                          apu_master_gnt_i,
  input  logic                          apu_master_valid_i,
  output logic [ADDR_W-1:0]             apu_waddr_o,
  output logic                          apu_wen_o,
  output logic                          apu_multicycle_o,
  output logic                          apu_singlecycle_o,
  output logic                          active_o,
  output logic                          stall_o,
  output logic                          read_dep_o,
  output logic                          write_dep_o,
  output logic                          perf_type_o,
  output logic                          perf_cont_o,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
  output logic                          spurious_o,
  input  logic                          perf_clr_i,
  output logic [31:0]                   perf_type_cnt_o,
  output logic [31:0]                   perf_cont_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  lat_t               r_last_lat;
  lat_t               w_lat;
  lat_t               w_head_lat;
  entry_t             w_push_entry;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty, w_full;
  logic               w_stall_type, w_stall_nack, w_valid_req, w_accept;
  logic               w_same_ret, w_push, w_pop;
  logic               w_q_read_dep, w_q_write_dep;
  logic               w_in_read_dep, w_in_write_dep;

  assign w_lat        = lat_t'(apu_lat_i);
  assign w_stall_type = enable_i && !w_empty &&
                        ((w_lat == LAT_1) || (w_lat == LAT_MC) ||
                         ((w_lat == LAT_2) && (r_last_lat == LAT_MC)));
  assign w_valid_req  = enable_i && !w_full && !w_stall_type;
  assign w_stall_nack = w_valid_req && !apu_master_gnt_i;
  assign w_accept     = w_valid_req && apu_master_gnt_i;
  // A result arriving while nothing is outstanding belongs to the op being accepted now.
  assign w_same_ret   = w_accept && w_empty && apu_master_valid_i;
  assign w_push       = w_accept && !w_same_ret;
  assign w_pop        = apu_master_valid_i && !w_empty;

  assign w_push_entry.addr = ENTRY_ADDR_W'(apu_waddr_i);
  assign w_push_entry.lat  = w_lat;

  apu_disp_queue #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .N_RD  (N_RD),
    .N_WR  (N_WR)
  ) u_queue (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .push_i            (w_push),
    .push_entry_i      (w_push_entry),
    .pop_i             (w_pop),
    .read_regs_i       (read_regs_i),
    .read_regs_valid_i (read_regs_valid_i),
    .write_regs_i      (write_regs_i),
    .write_regs_valid_i(write_regs_valid_i),
    .head_addr_o       (w_head_addr),
    .head_lat_o        (w_head_lat),
    .occupancy_o       (w_count),
    .empty_o           (w_empty),
    .full_o            (w_full),
    .read_dep_o        (w_q_read_dep),
    .write_dep_o       (w_q_write_dep)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          r_last_lat <= LAT_NONE;
    else if (w_valid_req) r_last_lat <= w_lat;
  end

  always_comb begin
    w_in_read_dep  = 1'b0;
    w_in_write_dep = 1'b0;
    for (int j = 0; j < N_RD; j++)
      if (read_regs_valid_i[j] && (read_regs_i[j] == apu_waddr_i)) w_in_read_dep = 1'b1;
    for (int k = 0; k < N_WR; k++)
      if (write_regs_valid_i[k] && (write_regs_i[k] == apu_waddr_i)) w_in_write_dep = 1'b1;
  end

  assign read_dep_o  = w_q_read_dep  || (w_valid_req && !w_same_ret && w_in_read_dep);
  assign write_dep_o = w_q_write_dep || (w_valid_req && !w_same_ret && w_in_write_dep);

  assign apu_master_req_o   = w_valid_req;
  assign apu_master_ready_o = 1'b1;
  assign apu_wen_o          = w_same_ret || w_pop;
  assign apu_waddr_o        = w_same_ret ? apu_waddr_i : (w_pop ? w_head_addr : '0);
  assign apu_multicycle_o   = (r_last_lat == LAT_MC);
  assign active_o           = !w_empty;
  assign apu_singlecycle_o  = w_empty;
  assign stall_o            = w_full || w_stall_type || w_stall_nack;
  assign perf_type_o        = w_stall_type;
  assign perf_cont_o        = w_stall_nack;
  assign occupancy_o        = w_count;
  assign spurious_o         = apu_master_valid_i && w_empty && !w_accept;

`ifdef APU_DISP_PERF_EN
  logic [31:0] r_type_cnt, r_cont_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_type_cnt <= '0;
      r_cont_cnt <= '0;
    end else if (perf_clr_i) begin
      r_type_cnt <= '0;
      r_cont_cnt <= '0;
    end else begin
      if (w_stall_type && (r_type_cnt != '1)) r_type_cnt <= r_type_cnt + 32'd1;
      if (w_stall_nack && (r_cont_cnt != '1)) r_cont_cnt <= r_cont_cnt + 32'd1;
    end
  end

  assign perf_type_cnt_o = r_type_cnt;
  assign perf_cont_cnt_o = r_cont_cnt;
`else
  assign perf_type_cnt_o = 32'd0;
  assign perf_cont_cnt_o = 32'd0;
`endif

endmodule
